// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced button with press pulse and optional long-press clear (LONG_PRESS_CLEAR_EN)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic button_in,
  output logic enable_pulse,
  output logic clear_pulse,
  output logic button_state
);

  // A single-cycle debounce window still needs a one-bit counter.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          enable_q, enable_d;
  logic          hold_start;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state, debounce counter and registered press pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      enable_q <= enable_d;
    end
  end

  // Next-state logic: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    enable_d   = 1'b0;
    hold_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d  = PRESS_CHK;
          db_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          enable_d   = 1'b1;
          hold_start = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d  = RELEASE_CHK;
          db_cnt_d = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_CLEAR_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          clear_q, clear_d;

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hold_cnt_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      clear_q    <= clear_d;
    end
  end

  // Count held cycles, freeze during release checking, saturate so the clear fires once per press.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    clear_d    = 1'b0;
    if (hold_start) begin
      hold_cnt_d = '0;
    end else if ((state_q == HELD) && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      clear_d    = (hold_cnt_q == HOLD_PRE);
    end
  end

  assign clear_pulse = clear_q;
`else
  assign clear_pulse = 1'b0;
`endif

  assign enable_pulse = enable_q;
  assign button_state = (state_q == HELD) || (state_q == RELEASE_CHK);

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed scoreboard bench for button_conditioner
module tb_button_conditioner;

`ifdef LONG_PRESS_CLEAR_EN
  localparam bit LPC = 1'b1;
`else
  localparam bit LPC = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic button_in = 1'b0;
  logic enable_pulse, clear_pulse, button_state;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk(clk),
    .nrst(nrst),
    .button_in(button_in),
    .enable_pulse(enable_pulse),
    .clear_pulse(clear_pulse),
    .button_state(button_state)
  );

  always #5 clk = ~clk;

  // Drive one cycle, queue the expected {enable, clear, state} after the edge, then compare.
  task automatic step(input string tag, input logic b, input logic r,
                      input logic e_en, input logic e_clr, input logic e_st);
    logic [2:0] got, want;
    @(negedge clk);
    button_in = b;
    nrst = r;
    sb.push_back({e_en, e_clr, e_st});
    @(posedge clk);
    #1;
    got = {enable_pulse, clear_pulse, button_state};
    want = sb.pop_front();
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s {en,clr,st} got %b want %b", tag, got, want);
    end
    checks++;
    assert ((enable_pulse && clear_pulse) === 1'b0)
    else begin
      errors++;
      $error("FAIL %s_exclusive got en=%b clr=%b want not both", tag, enable_pulse, clear_pulse);
    end
  endtask

  // Press held for len cycles starting at edge 1, observed for total cycles.
  task automatic press(input string tag, input int len, input int total);
    for (int k = 1; k <= total; k++) begin
      step(tag, (k <= len), 1'b1, (k == 7), (LPC && len >= 20 && k == 23),
           (k >= 7 && k <= len + 6));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with the button pressed: everything stays low.
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Clean press of 10 cycles: pulse after edge 7, state high edges 7..16.
    press("clean", 10, 24);
    idle(4);

    // Long press of 40 cycles: clear after edge 23 when the feature is built in.
    press("long", 40, 50);
    idle(4);

    // Bounce 1,1,0,0 repeated: never qualifies.
    for (int k = 1; k <= 16; k++) begin
      step("bounce", (k <= 8) && (((k - 1) % 4) < 2), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(4);

    // Two-cycle low glitch while held: stays held, hold count frozen two cycles.
    for (int k = 1; k <= 45; k++) begin
      step("glitch", (k <= 12) || (k >= 15 && k <= 30), 1'b1, (k == 7),
           (LPC && k == 25), (k >= 7 && k <= 36));
    end
    idle(4);

    // Reset at edge 5 of a short press: no pulse afterwards.
    for (int k = 1; k <= 20; k++) begin
      step("midreset", (k <= 6), (k != 5), 1'b0, 1'b0, 1'b0);
    end

    // A fresh press after the reset qualifies normally.
    press("fresh", 10, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
